// File: rtl/i2s_transmitter_pkg.sv
// Shared audio constants for the I2S output path.
// SAMPLE_WIDTH tracks the 16-voice mixer output width.
package i2s_transmitter_pkg;

   localparam int AUDIO_SAMPLE_WIDTH = 20;
   localparam int DEF_SLOT_WIDTH     = 32;
   localparam int DEF_BCLK_DIV       = 4;

   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } channel_e;

endpackage

// File: rtl/i2s_clock_gen.sv
// Bit clock / word select generator for the I2S link.
// Also produces the bclk-fall and frame-start strobes plus the next slot position.
module i2s_clock_gen
   import i2s_transmitter_pkg::*;
#(
   parameter int  SLOT_WIDTH = DEF_SLOT_WIDTH,
   parameter int  BCLK_DIV   = DEF_BCLK_DIV,
   localparam int POS_W      = $clog2(SLOT_WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   output logic             bclk,
   output logic             lrclk,
   output logic             fall,
   output logic             frame_start,
   output logic [POS_W-1:0] next_pos
);

   localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
   localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
   localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_WIDTH);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             bclk_q, bclk_d;
   channel_e         lrclk_q, lrclk_d;

   // bclk, lrclk and slot position are all derived from the post-edge counter values
   always_comb begin
      fall        = (div_cnt_q == DIV_LAST);
      frame_start = fall && (bit_cnt_q == BIT_LAST);
      div_cnt_d   = fall ? '0 : div_cnt_q + DIV_W'(1);
      bit_cnt_d   = bit_cnt_q;
      if (fall) begin
         bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
      end
      bclk_d   = (div_cnt_d >= DIV_HALF);
      lrclk_d  = (bit_cnt_d >= SLOT_LEN) ? CH_RIGHT : CH_LEFT;
      next_pos = (bit_cnt_d >= SLOT_LEN) ? POS_W'(bit_cnt_d - SLOT_LEN) : POS_W'(bit_cnt_d);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         bclk_q    <= 1'b0;
         lrclk_q   <= CH_LEFT;
      end else begin
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         bclk_q    <= bclk_d;
         lrclk_q   <= lrclk_d;
      end
   end

   assign bclk  = bclk_q;
   assign lrclk = lrclk_q;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter for the audio DAC: one-entry holding register, frame sample,
// MSB-first serialiser with one-bit delay, and underrun flag when no sample arrives in time.
module i2s_transmitter
   import i2s_transmitter_pkg::*;
#(
   parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
   parameter int SLOT_WIDTH   = DEF_SLOT_WIDTH,
   parameter int BCLK_DIV     = DEF_BCLK_DIV
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [SAMPLE_WIDTH-1:0] sampleData,
   input  logic                    sampleValid,
   output logic                    sampleReady,
   output logic                    bclk,
   output logic                    lrclk,
   output logic                    sdata,
   output logic                    underrun
);

   localparam int POS_W = $clog2(SLOT_WIDTH);

   logic                    fall;
   logic                    frame_start;
   logic [POS_W-1:0]        next_pos;
   logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;
   logic [SAMPLE_WIDTH-1:0] frame_q, frame_d;
   logic                    full_q, full_d;
   logic                    sdata_q, sdata_d;
   logic                    slot_bit;

   i2s_clock_gen #(
      .SLOT_WIDTH (SLOT_WIDTH),
      .BCLK_DIV   (BCLK_DIV)
   ) u_clock_gen (
      .clock       (clock),
      .reset       (reset),
      .bclk        (bclk),
      .lrclk       (lrclk),
      .fall        (fall),
      .frame_start (frame_start),
      .next_pos    (next_pos)
   );

   // Position 0 is the I2S pad bit; positions past the sample are zero fill.
   always_comb begin
      slot_bit = 1'b0;
      for (int i = 0; i < SAMPLE_WIDTH; i++) begin
         if (int'(next_pos) == SAMPLE_WIDTH - i) begin
            slot_bit = frame_q[i];
         end
      end
   end

   // A handshake needs !full_q, so it never collides with a load that empties the register.
   always_comb begin
      hold_d  = hold_q;
      full_d  = full_q;
      frame_d = frame_q;
      sdata_d = sdata_q;
      if (frame_start && full_q) begin
         frame_d = hold_q;
         full_d  = 1'b0;
      end
      if (sampleValid && !full_q) begin
         hold_d = sampleData;
         full_d = 1'b1;
      end
      if (fall) begin
         sdata_d = slot_bit;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_q  <= '0;
         frame_q <= '0;
         full_q  <= 1'b0;
         sdata_q <= 1'b0;
      end else begin
         hold_q  <= hold_d;
         frame_q <= frame_d;
         full_q  <= full_d;
         sdata_q <= sdata_d;
      end
   end

   assign sampleReady = !full_q;
   assign sdata       = sdata_q;
   assign underrun    = frame_start && !full_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter at default parameters (20-bit samples, 32-bit slots, bclk = clock/4).
module tb_i2s_transmitter;

   logic        clock;
   logic        reset;
   logic [19:0] sampleData;
   logic        sampleValid;
   logic        sampleReady;
   logic        bclk;
   logic        lrclk;
   logic        sdata;
   logic        underrun;

   int          n_asserts = 0;
   int          n_fail    = 0;
   int          cyc       = 0;
   int          offer_from = 0;
   bit          xfer_pending = 0;
   logic [19:0] pend_q[$];
   int          xfer_at[$];

   logic [63:0] bits;
   int          bclk_err, lr_err, stab_err, ur_cnt, ur_off;
   logic        prev_sdata;

   i2s_transmitter dut (
      .clock       (clock),
      .reset       (reset),
      .sampleData  (sampleData),
      .sampleValid (sampleValid),
      .sampleReady (sampleReady),
      .bclk        (bclk),
      .lrclk       (lrclk),
      .sdata       (sdata),
      .underrun    (underrun)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] slot_of(input logic [19:0] s);
      return {1'b0, s, 11'b0};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_inputs();
      if (pend_q.size() > 0 && cyc >= offer_from) begin
         sampleValid = 1'b1;
         sampleData  = pend_q[0];
      end else begin
         sampleValid = 1'b0;
         sampleData  = '0;
      end
   endtask

   // Called at a negative clock edge; cyc is the number of rising edges since reset release.
   task automatic observe();
      if (sampleValid && sampleReady) begin
         xfer_pending = 1'b1;
         xfer_at.push_back(cyc + 1);
      end
      if (cyc % 4 == 2) bits = {bits[62:0], sdata};
      if (bclk !== ((cyc % 4) >= 2)) bclk_err++;
      if (lrclk !== ((cyc % 256) >= 128)) lr_err++;
      if ((cyc % 4 != 0) && (sdata !== prev_sdata)) stab_err++;
      if (underrun === 1'b1) begin
         ur_cnt++;
         ur_off = cyc % 256;
      end
      prev_sdata = sdata;
   endtask

   task automatic step();
      @(posedge clock);
      cyc++;
      #1;
      if (xfer_pending) begin
         void'(pend_q.pop_front());
         xfer_pending = 1'b0;
      end
      drive_inputs();
      @(negedge clock);
   endtask

   task automatic run_window(input string name, input logic [63:0] exp_bits, input int exp_ur);
      bits     = '0;
      bclk_err = 0;
      lr_err   = 0;
      stab_err = 0;
      ur_cnt   = 0;
      ur_off   = -1;
      repeat (256) begin
         observe();
         step();
      end
      chk({name, " sdata"},      bits,           exp_bits);
      chk({name, " ur_count"},   64'(ur_cnt),    64'((exp_ur >= 0) ? 1 : 0));
      chk({name, " ur_offset"},  64'(ur_off),    64'(exp_ur));
      chk({name, " bclk"},       64'(bclk_err),  64'd0);
      chk({name, " lrclk"},      64'(lr_err),    64'd0);
      chk({name, " sdata_edge"}, 64'(stab_err),  64'd0);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, " bclk"},        64'(bclk),        64'd0);
      chk({name, " lrclk"},       64'(lrclk),       64'd0);
      chk({name, " sdata"},       64'(sdata),       64'd0);
      chk({name, " sampleReady"}, 64'(sampleReady), 64'd1);
      chk({name, " underrun"},    64'(underrun),    64'd0);
   endtask

   initial begin
      reset       = 1'b1;
      sampleValid = 1'b0;
      sampleData  = '0;
      prev_sdata  = 1'b0;
      repeat (3) @(negedge clock);
      chk_reset_outputs("reset");

      // Single sample offered before the first frame load.
      pend_q.push_back(20'h80001);
      offer_from = 0;
      drive_inputs();
      reset = 1'b0;
      cyc   = 0;

      run_window("frame0", 64'd0, -1);
      chk("xfer 80001 cycle", 64'(xfer_at[0]), 64'd1);
      run_window("frame1 80001", {32'h40000800, 32'h40000800}, 255);
      run_window("frame2 repeat", {slot_of(20'h80001), slot_of(20'h80001)}, 255);

      // Backpressure: two samples queued with sampleValid held high.
      pend_q.push_back(20'h12345);
      pend_q.push_back(20'h54321);
      drive_inputs();
      run_window("frame3 repeat", {slot_of(20'h80001), slot_of(20'h80001)}, -1);
      chk("xfer 12345 cycle", 64'(xfer_at[1]), 64'd769);
      chk("xfer count bp",    64'(xfer_at.size()), 64'd2);
      run_window("frame4 12345", {slot_of(20'h12345), slot_of(20'h12345)}, -1);
      chk("xfer 54321 cycle", 64'(xfer_at[2]), 64'd1025);

      // Handshake lands on the same edge as a load with an empty register.
      pend_q.push_back(20'hFFFFF);
      offer_from = 1535;
      run_window("frame5 54321", {slot_of(20'h54321), slot_of(20'h54321)}, 255);
      chk("xfer FFFFF cycle", 64'(xfer_at[3]), 64'd1536);
      run_window("frame6 old", {slot_of(20'h54321), slot_of(20'h54321)}, -1);
      run_window("frame7 FFFFF", {slot_of(20'hFFFFF), slot_of(20'hFFFFF)}, 255);

      // Fill the holding register, then reset at bitCnt=40 while bclk is high.
      pend_q.push_back(20'h0AAAA);
      offer_from = 2048;
      drive_inputs();
      while (cyc < 2210) begin
         observe();
         step();
      end
      chk("xfer 0AAAA cycle",  64'(xfer_at[4]),  64'd2049);
      chk("pre-reset ready",   64'(sampleReady), 64'd0);
      chk("pre-reset lrclk",   64'(lrclk),       64'd1);
      chk("pre-reset bclk",    64'(bclk),        64'd1);
      chk("pre-reset sdata",   64'(sdata),       64'd1);
      #1;
      reset = 1'b1;
      #1;
      chk_reset_outputs("midreset");
      repeat (3) @(negedge clock);
      chk_reset_outputs("midreset held");
      reset = 1'b0;
      cyc   = 0;
      run_window("post-reset frame0", 64'd0, 255);
      chk("xfer total", 64'(xfer_at.size()), 64'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
